// File: rtl/udp_pkg.sv
// Shared types and constants for the 128-bit UDP sender/receiver pair.
package udp_pkg;

  localparam int          BYTES_PER_WORD = 16;
  localparam int          UDP_HEAD_BYTES = 2;
  localparam logic [15:0] MIN_UDP_LEN    = 16'd2;

  typedef enum logic [2:0] {
    IDLE,
    HEAD_LO,
    PAYLOAD,
    FLUSH,
    DONE,
    DRAIN
  } recv_state_t;

  typedef struct packed {
    logic        last_frame_flag;
    logic [14:0] frame_rank;
  } udp_header_t;

  function automatic logic [15:0] jpeg_len_of(input logic [15:0] udp_len);
    return udp_len - 16'(UDP_HEAD_BYTES);
  endfunction

endpackage

// File: rtl/udp_byte_packer.sv
// Packs payload bytes MSB-first into 128-bit words and presents them on a
// valid/ready holding register; a word finishing while the holder is stalled is dropped.
module udp_byte_packer
  import udp_pkg::*;
(
  input  logic         clk,
  input  logic         srst,
  input  logic         clear_ovf,
  input  logic         start,
  input  logic         byte_en,
  input  logic [7:0]   byte_data,
  input  logic [15:0]  jpeg_len,
  input  logic         force_last,
  input  logic         ready,
  output logic [127:0] wrdata,
  output logic         valid,
  output logic         last,
  output logic         overflow,
  output logic         is_last
);

  logic [15:0]  cnt_reg;
  logic [127:0] asm_reg;
  logic [127:0] asm_next;
  logic [127:0] hold_reg;
  logic         valid_reg;
  logic         last_reg;
  logic         ovf_reg;
  logic [3:0]   pos;
  logic         frame_end;
  logic         word_done;
  logic         load;

  assign pos       = cnt_reg[3:0];
  assign is_last   = (cnt_reg == jpeg_len - 16'd1);
  assign frame_end = is_last || force_last;
  assign word_done = byte_en && ((pos == 4'd15) || frame_end);
  assign load      = word_done && (!valid_reg || ready);

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign asm_next[127-8*gi -: 8] = (pos == 4'(gi)) ? byte_data : asm_reg[127-8*gi -: 8];
    end
  endgenerate

  // asm_reg is cleared after every word, so unused low bytes are already zero
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg   <= '0;
      asm_reg   <= '0;
      hold_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (start) begin
        cnt_reg <= '0;
        asm_reg <= '0;
      end else if (byte_en) begin
        cnt_reg <= cnt_reg + 16'd1;
        asm_reg <= word_done ? '0 : asm_next;
      end

      if (clear_ovf) begin
        ovf_reg <= 1'b0;
      end

      if (load) begin
        hold_reg  <= asm_next;
        valid_reg <= 1'b1;
        last_reg  <= frame_end;
      end else begin
        if (valid_reg && ready) begin
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
        end
        if (word_done) begin
          ovf_reg <= 1'b1;
        end
      end
    end
  end

  assign wrdata   = hold_reg;
  assign valid    = valid_reg;
  assign last     = last_reg;
  assign overflow = ovf_reg;

endmodule

// File: rtl/udp_128bit_recv.sv
// UDP receive side: strips the 2-byte frame header and streams JPEG payload as 128-bit words.
// Optional eof/length cross-check is enabled with UDP_RECV_LEN_CHECK_EN.
module udp_128bit_recv
  import udp_pkg::*;
(
  input  logic         i_udp_clk50m,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_udp_rx_sof,
  input  logic         i_udp_rx_de,
  input  logic [7:0]   i_udp_data,
  input  logic         i_udp_rx_eof,
  input  logic [15:0]  i_udp_data_len,
  output logic [127:0] o_ddr3_udp_wrdata,
  output logic         o_ddr3_wr_valid,
  input  logic         i_ddr3_wr_ready,
  output logic         o_ddr3_wr_last,
  output logic         o_last_frame_flag,
  output logic [14:0]  o_mjpeg_frame_rank,
  output logic [15:0]  o_udp_jpeg_len,
  output logic         o_frame_done,
  output logic         o_busy,
  output logic         o_overflow,
  output logic         o_len_err
);

  recv_state_t  state_reg;
  logic [15:0]  len_reg;
  logic [7:0]   head_hi_reg;
  logic         last_flag_reg;
  logic [14:0]  rank_reg;
  logic [15:0]  jpeg_len_reg;
  logic         frame_done_reg;
  logic         busy_reg;
  udp_header_t  hdr;
  logic         sof_take;
  logic         byte_en;
  logic         pk_start;
  logic         is_last;
  logic         force_last;
  logic         eof_byte;

  assign sof_take = (state_reg == IDLE) && i_udp_rx_sof && i_udp_rx_de && i_en;
  assign byte_en  = (state_reg == PAYLOAD) && i_udp_rx_de;
  assign pk_start = (state_reg == HEAD_LO) && i_udp_rx_de;
  assign eof_byte = i_udp_rx_de && i_udp_rx_eof;
  assign hdr      = {head_hi_reg, i_udp_data};

`ifdef UDP_RECV_LEN_CHECK_EN
  logic drain_after_reg;
  logic len_err_reg;
  // an eof ahead of the declared length closes the partial word as the last one
  assign force_last = byte_en && i_udp_rx_eof && !is_last;
  assign o_len_err  = len_err_reg;
`else
  assign force_last = 1'b0;
  assign o_len_err  = 1'b0;
`endif

  always_ff @(posedge i_udp_clk50m) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      head_hi_reg    <= '0;
      last_flag_reg  <= 1'b0;
      rank_reg       <= '0;
      jpeg_len_reg   <= '0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef UDP_RECV_LEN_CHECK_EN
      drain_after_reg <= 1'b0;
      len_err_reg     <= 1'b0;
`endif
    end else begin
      frame_done_reg <= 1'b0;
`ifdef UDP_RECV_LEN_CHECK_EN
      len_err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (sof_take) begin
            if (i_udp_data_len < MIN_UDP_LEN) begin
              // a runt datagram whose only byte carries eof needs no draining
              if (!i_udp_rx_eof) state_reg <= DRAIN;
            end else begin
              len_reg     <= i_udp_data_len;
              head_hi_reg <= i_udp_data;
              busy_reg    <= 1'b1;
              state_reg   <= HEAD_LO;
            end
          end
        end
        HEAD_LO: begin
          if (i_udp_rx_de) begin
            last_flag_reg <= hdr.last_frame_flag;
            rank_reg      <= hdr.frame_rank;
            jpeg_len_reg  <= jpeg_len_of(len_reg);
            if (len_reg == MIN_UDP_LEN) begin
              state_reg      <= DONE;
              frame_done_reg <= 1'b1;
            end else begin
              state_reg <= PAYLOAD;
            end
`ifdef UDP_RECV_LEN_CHECK_EN
            if ((len_reg == MIN_UDP_LEN) != i_udp_rx_eof) len_err_reg <= 1'b1;
            if ((len_reg == MIN_UDP_LEN) && !i_udp_rx_eof) drain_after_reg <= 1'b1;
            if ((len_reg != MIN_UDP_LEN) && i_udp_rx_eof) begin
              state_reg      <= DONE;
              frame_done_reg <= 1'b1;
            end
`endif
          end
        end
        PAYLOAD: begin
          if (byte_en && (is_last || force_last)) state_reg <= FLUSH;
`ifdef UDP_RECV_LEN_CHECK_EN
          if (byte_en && (force_last || (is_last && !i_udp_rx_eof))) len_err_reg <= 1'b1;
          if (byte_en && is_last && !i_udp_rx_eof) drain_after_reg <= 1'b1;
`endif
        end
        FLUSH: begin
          if (!o_ddr3_wr_valid || i_ddr3_wr_ready) begin
            state_reg      <= DONE;
            frame_done_reg <= 1'b1;
          end
`ifdef UDP_RECV_LEN_CHECK_EN
          if (eof_byte) drain_after_reg <= 1'b0;
`endif
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
`ifdef UDP_RECV_LEN_CHECK_EN
          if (drain_after_reg && !eof_byte) state_reg <= DRAIN;
          drain_after_reg <= 1'b0;
`endif
        end
        DRAIN: begin
          if (eof_byte) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  udp_byte_packer u_packer (
    .clk        (i_udp_clk50m),
    .srst       (i_rst),
    .clear_ovf  (sof_take),
    .start      (pk_start),
    .byte_en    (byte_en),
    .byte_data  (i_udp_data),
    .jpeg_len   (jpeg_len_reg),
    .force_last (force_last),
    .ready      (i_ddr3_wr_ready),
    .wrdata     (o_ddr3_udp_wrdata),
    .valid      (o_ddr3_wr_valid),
    .last       (o_ddr3_wr_last),
    .overflow   (o_overflow),
    .is_last    (is_last)
  );

  assign o_last_frame_flag  = last_flag_reg;
  assign o_mjpeg_frame_rank = rank_reg;
  assign o_udp_jpeg_len     = jpeg_len_reg;
  assign o_frame_done       = frame_done_reg;
  assign o_busy             = busy_reg;

endmodule

// File: doc/udp_128bit_recv.md
# udp_128bit_recv

Receive-side counterpart of the 128-bit UDP sender: accepts the byte-serial UDP payload stream from the UDP/MAC receive path, strips the 2-byte frame header {last_frame_flag, mjpeg_frame_rank[14:0]}, packs the JPEG bytes MSB-first into 128-bit words and hands each word to the DDR3 write side with a valid/ready handshake. It sits between the UDP receive core and the DDR3 frame-buffer writer in the 50 MHz UDP clock domain.

## Interface
- BYTES_PER_WORD, 16, bytes packed per output word; fixed by the 128-bit DDR3 path.
- MIN_UDP_LEN, 2, smallest legal i_udp_data_len, which is the header-only datagram.

- i_udp_clk50m  in  1  UDP clock, 50 MHz; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  level; receiver accepts a new datagram only while high.
- i_udp_rx_sof  in  1  one-cycle pulse coincident with the first payload byte.
- i_udp_rx_de  in  1  payload byte valid.
- i_udp_data  in  8  payload byte.
- i_udp_rx_eof  in  1  marks the last datagram byte; qualified by i_udp_rx_de.
- i_udp_data_len  in  16  payload length including the 2 header bytes; sampled on the sof cycle.
- o_ddr3_udp_wrdata  out  128  packed word; byte 0 at [127:120].
- o_ddr3_wr_valid  out  1  word valid; held until i_ddr3_wr_ready.
- i_ddr3_wr_ready  in  1  DDR3 side accepts the word.
- o_ddr3_wr_last  out  1  qualifies the final word of the frame.
- o_last_frame_flag  out  1  header bit 15, held from capture until the next sof.
- o_mjpeg_frame_rank  out  15  header bits 14:0, held with o_last_frame_flag.
- o_udp_jpeg_len  out  16  i_udp_data_len − 2, held.
- o_frame_done  out  1  one-cycle pulse.
- o_busy  out  1  high from sof through frame done.
- o_overflow  out  1  sticky.
- o_len_err  out  1  one-cycle pulse; driven only when UDP_RECV_LEN_CHECK_EN is defined, otherwise tied 0.

## Operation
- **Reset values.** All outputs 0. State IDLE. Counters and buffers cleared.
- **IDLE.**
  - A sof with i_de and i_en: byte 0 is the header MSB. Latch len to HEAD_LO.
  - If i_udp_data_len < MIN_UDP_LEN: go to DRAIN without asserting o_busy.
  - A sof while i_en is low is ignored.
- **HEAD_LO.** The next de byte completes the header.
  - Update o_last_frame_flag, o_mjpeg_frame_rank and o_udp_jpeg_len.
  - Clear the byte count. Go to PAYLOAD.
  - If jpeg_len == 0: go to DONE.
- **PAYLOAD.** Each de byte is shifted into the assembly register at byte position cnt[3:0], MSB-first.
  - On the 16th byte, or on the jpeg_len-th byte: move the word into the holding register with unused low bytes zeroed, and set o_ddr3_wr_valid.
  - Set o_ddr3_wr_last when the word contains byte jpeg_len−1.
  - The last byte goes to FLUSH.
- **FLUSH.** Wait for valid&ready on the last word, then go to DONE.
- **DONE.** Pulse o_frame_done for one cycle. Drop o_busy. Go to IDLE.
- **DRAIN.** Discard de bytes up to and including eof, then go to IDLE.
- **Overflow.**
  - If a word completes while the holding register is still valid and not ready: drop the new word.
  - Set o_overflow. It clears only on i_rst, or on a sof accepted in IDLE.
- **Count arithmetic.** 16-bit compare cnt == jpeg_len − 1. jpeg_len is at most 65533, so there is no wrap.
- **sof mid-frame.** Ignored. The frame runs to its declared length.
- **Reset mid-frame.** Drops the frame. No o_frame_done is asserted.

## Timing
- Word valid is asserted the cycle after its last byte is accepted.
- o_ddr3_wr_valid and o_ddr3_udp_wrdata stay stable while not ready.
- The DDR3 side must accept within 16 cycles at full byte rate to avoid overflow.
- o_frame_done rises the cycle after the last word is accepted.
- For jpeg_len == 0, o_frame_done rises the cycle after the header low byte is accepted.
- A new sof is accepted in the cycle after o_frame_done.

## Configuration
- **UDP_RECV_LEN_CHECK_EN defined.** eof is checked against the declared length.
  - eof before the last byte: flush the partial word with wr_last set, pulse o_len_err, finish normally.
  - Last byte reached without eof: pulse o_len_err, pass through FLUSH/DONE, then DRAIN to eof.
- **UDP_RECV_LEN_CHECK_EN undefined.** Termination is by count only. eof is ignored outside DRAIN. o_len_err is 0.

## Structure
- **Shared package udp_pkg.**
  - Receive state enum: IDLE, HEAD_LO, PAYLOAD, FLUSH, DONE, DRAIN.
  - Constant UDP_HEAD_BYTES = 2.
  - Header struct {last_frame_flag, frame_rank[14:0]}, also used by the sender.
- **Sub-module udp_byte_packer.** Assembly register, byte counter and holding register with the valid/ready and overflow logic. The top level holds the FSM.

## Test plan
- **Basic frame.** len=18, header 0x8005, then bytes 0x00..0x0F, ready=1.
  - One word 0x000102…0F with wr_last=1.
  - last_flag=1, rank=5, jpeg_len=16.
  - o_frame_done 2 cycles after the last byte.
- **Partial word.** len=23, 21 payload bytes.
  - Two words.
  - Second word = bytes 16..20 in [127:88], rest 0, wr_last=1.
- **Header only.** len=2, header 0x0003.
  - No wr_valid.
  - o_frame_done the cycle after the second byte.
  - rank=3.
- **Overflow.** ready held 0 for 40 cycles across a 48-byte payload.
  - First word held stable.
  - Second word dropped.
  - o_overflow=1 until the next sof.
- **Length error.** With UDP_RECV_LEN_CHECK_EN defined, len=34 and eof on payload byte 10.
  - Partial word holds 10 bytes, wr_last=1.
  - o_len_err pulse, o_frame_done.
- **Reset mid-frame.** i_rst asserted mid-PAYLOAD, then a new frame.
  - All outputs 0 the cycle after reset.
  - No frame_done for the aborted frame.
  - The next sof frame is received correctly.
